// File: rtl/fu_issue_arbiter_pkg.sv
// Shared FU identifiers and widths for the issue queue and the issue arbiter.
// The FU id field is FU_ID_W bits wide; any id at or above FU_COUNT is treated as "no unit".
package fu_issue_arbiter_pkg;

    localparam int FU_ID_W  = 2;
    localparam int FU_COUNT = 3;

    typedef enum logic [FU_ID_W-1:0] {
        FU_ALU0 = 2'd0,
        FU_ALU1 = 2'd1,
        FU_LSU  = 2'd2,
        FU_NONE = 2'd3
    } fu_id_e;

    function automatic logic fu_in_range(input logic [FU_ID_W-1:0] fu, input int n_fu);
        return int'(fu) < n_fu;
    endfunction

endpackage

// File: rtl/fu_issue_arbiter_rr_find_first.sv
// Rotating-priority find-first: returns the first set bit of req_vec at or after start_idx,
// wrapping from WIDTH-1 back to 0.
module rr_find_first #(
    parameter int WIDTH = 16,
    parameter int IDX_W = 4
) (
    input  logic [WIDTH-1:0] req_vec,
    input  logic [IDX_W-1:0] start_idx,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    int scan_j;

    // Walk the offsets from farthest to nearest so the nearest hit is the one that sticks.
    always_comb begin
        found  = 1'b0;
        idx    = '0;
        scan_j = 0;
        for (int k = WIDTH - 1; k >= 0; k--) begin
            scan_j = int'(start_idx) + k;
            if (scan_j >= WIDTH) begin
                scan_j = scan_j - WIDTH;
            end
            if (req_vec[scan_j]) begin
                found = 1'b1;
                idx   = IDX_W'(scan_j);
            end
        end
    end

endmodule

// File: rtl/fu_issue_arbiter.sv
// Dual-issue arbiter: picks up to two ready issue-queue entries per cycle, one per FU,
// with round-robin fairness and a down-counter modelling LSU occupancy.
module fu_issue_arbiter
    import fu_issue_arbiter_pkg::*;
#(
    parameter int RS_SIZE  = 16,
    parameter int RS_IDX   = 4,
    parameter int FU_ARRAY = FU_COUNT,
    parameter int FU_SIZE  = FU_ID_W,
    parameter int LSU_LAT  = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [RS_SIZE-1:0]         req_valid_in,
    input  logic [FU_SIZE*RS_SIZE-1:0] req_fu_in,
    input  logic [FU_ARRAY-1:0]        fu_ready_in,
    input  logic                       flush_in,
    output logic                       grant_valid1_out,
    output logic                       grant_valid2_out,
    output logic [RS_IDX-1:0]          grant_idx1_out,
    output logic [RS_IDX-1:0]          grant_idx2_out,
    output logic [FU_SIZE-1:0]         grant_fu1_out,
    output logic [FU_SIZE-1:0]         grant_fu2_out,
    output logic [RS_SIZE-1:0]         grant_vec_out,
    output logic [FU_ARRAY-1:0]        fu_busy_out
);

    localparam int                CNT_W      = (LSU_LAT > 1) ? $clog2(LSU_LAT) : 1;
    localparam logic [CNT_W-1:0]  LSU_RELOAD = CNT_W'(LSU_LAT - 1);
    localparam logic [FU_SIZE-1:0] LSU_ID    = FU_SIZE'(FU_LSU);

    logic [RS_IDX-1:0]  rr_ptr;
    logic [RS_IDX-1:0]  rr_ptr_d;
    logic [CNT_W-1:0]   lsu_cnt;

    logic [FU_SIZE-1:0] entry_fu [RS_SIZE];
    logic [RS_SIZE-1:0] eligible;
    logic [RS_SIZE-1:0] slot2_mask;
    logic [FU_ARRAY-1:0] fu_busy;

    logic               s1_found;
    logic               s2_found;
    logic [RS_IDX-1:0]  s1_idx;
    logic [RS_IDX-1:0]  s2_idx;
    logic [RS_IDX-1:0]  s2_start;
    logic               s1_valid;
    logic               s2_valid;
    logic [FU_SIZE-1:0] s1_fu;
    logic [FU_SIZE-1:0] s2_fu;
    logic [RS_SIZE-1:0] grant_vec_d;
    logic               lsu_grant;

    function automatic logic [RS_IDX-1:0] wrap_inc(input logic [RS_IDX-1:0] x);
        if (int'(x) == RS_SIZE - 1) begin
            return '0;
        end
        return x + 1'b1;
    endfunction

    for (genvar g = 0; g < RS_SIZE; g++) begin : g_entry_fu
        assign entry_fu[g] = req_fu_in[FU_SIZE*g +: FU_SIZE];
    end

    // Only the LSU has multi-cycle occupancy; the ALUs are fully pipelined.
    always_comb begin
        fu_busy = '0;
        if (FU_ARRAY > int'(FU_LSU)) begin
            fu_busy[FU_LSU] = (lsu_cnt != '0);
        end
    end

    assign fu_busy_out = fu_busy;

    // Entries granted last cycle are masked so the issue queue has time to drop them.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            if (fu_in_range(entry_fu[i], FU_ARRAY)) begin
                eligible[i] = req_valid_in[i]
                            & fu_ready_in[entry_fu[i]]
                            & ~fu_busy[entry_fu[i]]
                            & ~grant_vec_out[i];
            end
        end
    end

    rr_find_first #(
        .WIDTH (RS_SIZE),
        .IDX_W (RS_IDX)
    ) u_find_slot1 (
        .req_vec   (eligible),
        .start_idx (rr_ptr),
        .found     (s1_found),
        .idx       (s1_idx)
    );

    assign s1_valid = s1_found;
    assign s1_fu    = s1_valid ? entry_fu[s1_idx] : '0;

    // Slot 2 resumes the scan just past slot 1; entries between rr_ptr and slot 1
    // are already known to be ineligible, so the wrap-around cannot pick them.
    always_comb begin
        slot2_mask = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            slot2_mask[i] = eligible[i] & (entry_fu[i] != s1_fu);
        end
    end

    assign s2_start = wrap_inc(s1_idx);

    rr_find_first #(
        .WIDTH (RS_SIZE),
        .IDX_W (RS_IDX)
    ) u_find_slot2 (
        .req_vec   (slot2_mask),
        .start_idx (s2_start),
        .found     (s2_found),
        .idx       (s2_idx)
    );

    assign s2_valid = s1_found & s2_found;
    assign s2_fu    = s2_valid ? entry_fu[s2_idx] : '0;

    always_comb begin
        grant_vec_d = '0;
        if (s1_valid) begin
            grant_vec_d[s1_idx] = 1'b1;
        end
        if (s2_valid) begin
            grant_vec_d[s2_idx] = 1'b1;
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr;
        if (s2_valid) begin
            rr_ptr_d = wrap_inc(s2_idx);
        end else if (s1_valid) begin
            rr_ptr_d = wrap_inc(s1_idx);
        end
    end

    assign lsu_grant = (s1_valid && (s1_fu == LSU_ID)) || (s2_valid && (s2_fu == LSU_ID));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_valid1_out <= 1'b0;
            grant_valid2_out <= 1'b0;
            grant_idx1_out   <= '0;
            grant_idx2_out   <= '0;
            grant_fu1_out    <= '0;
            grant_fu2_out    <= '0;
            grant_vec_out    <= '0;
            rr_ptr           <= '0;
            lsu_cnt          <= '0;
        end else if (flush_in) begin
            grant_valid1_out <= 1'b0;
            grant_valid2_out <= 1'b0;
            grant_idx1_out   <= '0;
            grant_idx2_out   <= '0;
            grant_fu1_out    <= '0;
            grant_fu2_out    <= '0;
            grant_vec_out    <= '0;
            rr_ptr           <= '0;
            lsu_cnt          <= '0;
        end else begin
            grant_valid1_out <= s1_valid;
            grant_valid2_out <= s2_valid;
            grant_idx1_out   <= s1_valid ? s1_idx : '0;
            grant_idx2_out   <= s2_valid ? s2_idx : '0;
            grant_fu1_out    <= s1_fu;
            grant_fu2_out    <= s2_fu;
            grant_vec_out    <= grant_vec_d;
            rr_ptr           <= rr_ptr_d;
            if (lsu_grant) begin
                lsu_cnt <= LSU_RELOAD;
            end else if (lsu_cnt != '0) begin
                lsu_cnt <= lsu_cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fu_issue_arbiter.sv
// Bench for fu_issue_arbiter: two instances (LSU_LAT=2 and LSU_LAT=1) share stimulus and are
// compared every cycle against a scan-order reference model; directed cases pin literal results.
module tb_fu_issue_arbiter;

    localparam int RS    = 16;
    localparam int LAT_A = 2;
    localparam int LAT_B = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] req_valid = '0;
    logic [31:0] req_fu = '0;
    logic [2:0]  fu_ready = 3'b111;
    logic        flush = 1'b0;

    logic        gv1 [2];
    logic        gv2 [2];
    logic [3:0]  gi1 [2];
    logic [3:0]  gi2 [2];
    logic [1:0]  gf1 [2];
    logic [1:0]  gf2 [2];
    logic [15:0] gvec [2];
    logic [2:0]  gbusy [2];

    logic        e_v1 [2], e_v2 [2], p_v1 [2], p_v2 [2];
    logic [3:0]  e_i1 [2], e_i2 [2], p_i1 [2], p_i2 [2];
    logic [1:0]  e_f1 [2], e_f2 [2], p_f1 [2], p_f2 [2];
    logic [15:0] e_vec [2], p_vec [2];
    logic [2:0]  e_busy [2], p_busy [2];

    int          m_rr [2];
    int          m_last [2];
    logic [15:0] m_prev [2];
    int          ecount = 0;

    int n_cmp = 0;
    int n_err = 0;
    bit check_en = 1'b0;

    always #5 clk = ~clk;

    fu_issue_arbiter #(.LSU_LAT(LAT_A)) u_dut0 (
        .clk(clk), .rst(rst), .req_valid_in(req_valid), .req_fu_in(req_fu),
        .fu_ready_in(fu_ready), .flush_in(flush),
        .grant_valid1_out(gv1[0]), .grant_valid2_out(gv2[0]),
        .grant_idx1_out(gi1[0]), .grant_idx2_out(gi2[0]),
        .grant_fu1_out(gf1[0]), .grant_fu2_out(gf2[0]),
        .grant_vec_out(gvec[0]), .fu_busy_out(gbusy[0])
    );

    fu_issue_arbiter #(.LSU_LAT(LAT_B)) u_dut1 (
        .clk(clk), .rst(rst), .req_valid_in(req_valid), .req_fu_in(req_fu),
        .fu_ready_in(fu_ready), .flush_in(flush),
        .grant_valid1_out(gv1[1]), .grant_valid2_out(gv2[1]),
        .grant_idx1_out(gi1[1]), .grant_idx2_out(gi2[1]),
        .grant_fu1_out(gf1[1]), .grant_fu2_out(gf2[1]),
        .grant_vec_out(gvec[1]), .fu_busy_out(gbusy[1])
    );

    task automatic chk(input string name, input int m, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s[dut%0d] at %0t: got 0x%0h expected 0x%0h", name, m, $time, act, expv);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_rr[m] = 0; m_last[m] = -1000; m_prev[m] = '0;
            e_v1[m] = 0; e_v2[m] = 0; e_i1[m] = 0; e_i2[m] = 0;
            e_f1[m] = 0; e_f2[m] = 0; e_vec[m] = 0; e_busy[m] = 0;
        end
    endtask

    // Predicts the outputs after the coming edge from the current inputs and model state.
    // LSU is usable at edge e iff at least LAT edges have passed since its last grant.
    task automatic model_step();
        int e, f, lat, i1, i2, k1, j;
        bit f1, f2;
        logic [15:0] elig, vec;
        e = ecount + 1;
        for (int m = 0; m < 2; m++) begin
            lat = (m == 0) ? LAT_A : LAT_B;
            if (flush) begin
                p_v1[m] = 0; p_v2[m] = 0; p_i1[m] = 0; p_i2[m] = 0;
                p_f1[m] = 0; p_f2[m] = 0; p_vec[m] = 0; p_busy[m] = 0;
                m_rr[m] = 0; m_last[m] = -1000; m_prev[m] = '0;
            end else begin
                for (int i = 0; i < RS; i++) begin
                    f = int'(req_fu[2*i +: 2]);
                    elig[i] = 1'b0;
                    if (req_valid[i] && f < 3 && !m_prev[m][i]) begin
                        if (fu_ready[f] && !(f == 2 && (e - m_last[m]) < lat)) elig[i] = 1'b1;
                    end
                end
                f1 = 0; f2 = 0; i1 = 0; i2 = 0; k1 = 0;
                for (int k = 0; k < RS; k++) begin
                    j = (m_rr[m] + k) % RS;
                    if (!f1 && elig[j]) begin f1 = 1; i1 = j; k1 = k; end
                end
                if (f1) begin
                    for (int k = k1 + 1; k < RS; k++) begin
                        j = (m_rr[m] + k) % RS;
                        if (!f2 && elig[j] && req_fu[2*j +: 2] != req_fu[2*i1 +: 2]) begin
                            f2 = 1; i2 = j;
                        end
                    end
                end
                vec = '0;
                if (f1) vec[i1] = 1'b1;
                if (f2) vec[i2] = 1'b1;
                p_v1[m] = f1; p_v2[m] = f2;
                p_i1[m] = f1 ? 4'(i1) : 4'd0;
                p_i2[m] = f2 ? 4'(i2) : 4'd0;
                p_f1[m] = f1 ? req_fu[2*i1 +: 2] : 2'd0;
                p_f2[m] = f2 ? req_fu[2*i2 +: 2] : 2'd0;
                p_vec[m] = vec;
                if (f2) m_rr[m] = (i2 + 1) % RS;
                else if (f1) m_rr[m] = (i1 + 1) % RS;
                if ((f1 && p_f1[m] == 2'd2) || (f2 && p_f2[m] == 2'd2)) m_last[m] = e;
                m_prev[m] = vec;
                p_busy[m] = ((e - m_last[m]) < lat - 1) ? 3'b100 : 3'b000;
            end
        end
        ecount = e;
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        for (int m = 0; m < 2; m++) begin
            e_v1[m] = p_v1[m]; e_v2[m] = p_v2[m]; e_i1[m] = p_i1[m]; e_i2[m] = p_i2[m];
            e_f1[m] = p_f1[m]; e_f2[m] = p_f2[m]; e_vec[m] = p_vec[m]; e_busy[m] = p_busy[m];
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            for (int m = 0; m < 2; m++) begin
                chk("valid1", m, 32'(gv1[m]), 32'(e_v1[m]));
                chk("valid2", m, 32'(gv2[m]), 32'(e_v2[m]));
                chk("idx1", m, 32'(gi1[m]), 32'(e_i1[m]));
                chk("idx2", m, 32'(gi2[m]), 32'(e_i2[m]));
                chk("fu1", m, 32'(gf1[m]), 32'(e_f1[m]));
                chk("fu2", m, 32'(gf2[m]), 32'(e_f2[m]));
                chk("vec", m, 32'(gvec[m]), 32'(e_vec[m]));
                chk("busy", m, 32'(gbusy[m]), 32'(e_busy[m]));
            end
        end
    end

    task automatic clr();
        req_valid = '0;
        req_fu    = '0;
    endtask

    task automatic setr(input int i, input int f);
        req_valid[i]     = 1'b1;
        req_fu[2*i +: 2] = 2'(f);
    endtask

    task automatic flush_cycle();
        flush = 1'b1;
        cycle();
        flush = 1'b0;
    endtask

    // Asynchronous reset asserted away from the clock edge; outputs must clear at once.
    task automatic do_reset(input string tag);
        rst = 1'b1;
        model_reset();
        #1;
        chk({tag, "_busy"}, 0, 32'(gbusy[0]), 32'h0);
        chk({tag, "_valid1"}, 0, 32'(gv1[0]), 32'h0);
        chk({tag, "_vec"}, 0, 32'(gvec[0]), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid1", 0, 32'(gv1[0]), 32'h0);
        chk("rst_idx1", 0, 32'(gi1[0]), 32'h0);
        chk("rst_vec", 0, 32'(gvec[0]), 32'h0);
        chk("rst_busy", 0, 32'(gbusy[0]), 32'h0);
        rst = 1'b0;
        check_en = 1'b1;

        // Two ALU requests from rr_ptr=0, then a follow-up that reveals rr_ptr=6.
        clr(); setr(3, 0); setr(5, 1); fu_ready = 3'b111;
        cycle();
        chk("r029_idx1", 0, 32'(gi1[0]), 32'd3);
        chk("r029_fu1", 0, 32'(gf1[0]), 32'd0);
        chk("r029_idx2", 0, 32'(gi2[0]), 32'd5);
        chk("r029_fu2", 0, 32'(gf2[0]), 32'd1);
        chk("r029_vec", 0, 32'(gvec[0]), 32'h0028);
        clr(); setr(4, 0); setr(6, 1);
        cycle();
        chk("r029_rr_idx1", 0, 32'(gi1[0]), 32'd6);
        chk("r029_rr_idx2", 0, 32'(gi2[0]), 32'd4);

        // Wrap-around from rr_ptr=14.
        clr(); flush_cycle();
        chk("flush_valid1", 0, 32'(gv1[0]), 32'h0);
        setr(13, 0);
        cycle();
        chk("r031_pre_idx1", 0, 32'(gi1[0]), 32'd13);
        clr(); setr(15, 0); setr(0, 1);
        cycle();
        chk("r031_idx1", 0, 32'(gi1[0]), 32'd15);
        chk("r031_idx2", 0, 32'(gi2[0]), 32'd0);
        chk("r031_valid2", 0, 32'(gv2[0]), 32'd1);
        clr(); setr(0, 0); setr(1, 1);
        cycle();
        chk("r031_rr_idx1", 0, 32'(gi1[0]), 32'd1);
        chk("r031_masked_v2", 0, 32'(gv2[0]), 32'd0);

        // Unready FU gives no grant and leaves rr_ptr at 2.
        clr(); fu_ready = 3'b101; setr(4, 1);
        cycle();
        chk("r032_valid1", 0, 32'(gv1[0]), 32'd0);
        chk("r032_vec", 0, 32'(gvec[0]), 32'h0);
        fu_ready = 3'b111; clr(); setr(2, 0); setr(1, 1);
        cycle();
        chk("r032_rr_idx1", 0, 32'(gi1[0]), 32'd2);
        chk("r032_rr_idx2", 0, 32'(gi2[0]), 32'd1);

        // A held request is not re-granted on the cycle after its grant.
        clr(); setr(7, 0);
        cycle();
        chk("r033_first", 0, 32'(gi1[0]), 32'd7);
        cycle();
        chk("r033_masked", 0, 32'(gv1[0]), 32'd0);
        cycle();
        chk("r033_again", 0, 32'(gi1[0]), 32'd7);

        // Two LSU requests: LSU_LAT=2 spaces the grants, LSU_LAT=1 grants back to back.
        clr(); flush_cycle();
        setr(1, 2); setr(2, 2);
        cycle();
        chk("r030_n1_idx1", 0, 32'(gi1[0]), 32'd1);
        chk("r030_n1_fu1", 0, 32'(gf1[0]), 32'd2);
        chk("r030_n1_v2", 0, 32'(gv2[0]), 32'd0);
        chk("r030_n1_busy", 0, 32'(gbusy[0]), 32'h4);
        chk("r021_n1_busy", 1, 32'(gbusy[1]), 32'h0);
        cycle();
        chk("r030_n2_valid1", 0, 32'(gv1[0]), 32'd0);
        chk("r021_n2_idx1", 1, 32'(gi1[1]), 32'd2);
        chk("r021_n2_valid1", 1, 32'(gv1[1]), 32'd1);
        cycle();
        chk("r030_n3_idx1", 0, 32'(gi1[0]), 32'd2);
        chk("r030_n3_busy", 0, 32'(gbusy[0]), 32'h4);
        chk("r021_n3_idx1", 1, 32'(gi1[1]), 32'd1);

        // Flush during LSU occupancy, then reset during occupancy.
        flush_cycle();
        chk("r034_flush_v1", 0, 32'(gv1[0]), 32'd0);
        chk("r034_flush_busy", 0, 32'(gbusy[0]), 32'h0);
        chk("r034_flush_vec", 0, 32'(gvec[0]), 32'h0);
        cycle();
        chk("r034_post_flush_idx1", 0, 32'(gi1[0]), 32'd1);
        chk("r034_post_flush_busy", 0, 32'(gbusy[0]), 32'h4);
        do_reset("r034_rst");
        cycle();
        chk("r026_post_rst_idx1", 0, 32'(gi1[0]), 32'd1);
        chk("r026_post_rst_fu1", 0, 32'(gf1[0]), 32'd2);

        // Randomized traffic with occasional flushes and resets.
        for (int it = 0; it < 3000; it++) begin
            if (it == 1200 || it == 2400) do_reset("rand_rst");
            case ($urandom_range(0, 2))
                0: req_valid = 16'($urandom);
                1: req_valid = 16'($urandom & $urandom);
                default: req_valid = 16'($urandom & $urandom & $urandom);
            endcase
            req_fu = $urandom;
            if ($urandom_range(0, 5) == 0) req_fu = 32'haaaa_aaaa ^ ($urandom & 32'h1111_1111);
            for (int b = 0; b < 3; b++) fu_ready[b] = ($urandom_range(0, 4) != 0);
            flush = ($urandom_range(0, 40) == 0);
            cycle();
        end
        flush = 1'b0;
        @(posedge clk);
        #1;
        check_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fu_issue_arbiter.md
FU_ISSUE_ARBITER -- requirements
Module: fu_issue_arbiter

Interface
REQ-001 SHALL have parameters: RS_SIZE, default 16, issue-queue entries; RS_IDX, default 4, entry index width; FU_ARRAY, default 3, FU count (0=ALU0, 1=ALU1, 2=LSU); FU_SIZE, default 2, FU-id width; LSU_LAT, default 2, LSU occupancy cycles per grant (>=1).
REQ-002 SHALL have port clk, input, 1, single clock; all logic samples on posedge clk.
REQ-003 SHALL have port rst, input, 1, asynchronous, active-high reset.
REQ-004 SHALL have port req_valid_in, input, RS_SIZE, bit i=1: entry i valid and both sources ready.
REQ-005 SHALL have port req_fu_in, input, FU_SIZE*RS_SIZE, packed FU id of entry i at bits [FU_SIZE*i +: FU_SIZE].
REQ-006 SHALL have port fu_ready_in, input, FU_ARRAY, bit f=1: FU f accepts an op this cycle.
REQ-007 SHALL have port flush_in, input, 1, synchronous pipeline flush.
REQ-008 SHALL have ports grant_valid1_out/grant_valid2_out, output, 1 each, issue slot 1/2 valid.
REQ-009 SHALL have ports grant_idx1_out/grant_idx2_out, output, RS_IDX each, granted entry index.
REQ-010 SHALL have ports grant_fu1_out/grant_fu2_out, output, FU_SIZE each, destination FU.
REQ-011 SHALL have port grant_vec_out, output, RS_SIZE, one bit per granted entry (issue queue clears valid from it).
REQ-012 SHALL have port fu_busy_out, output, FU_ARRAY, internal busy state per FU.

Function
REQ-013 Entry i SHALL be eligible iff req_valid_in[i], fu_ready_in[fu(i)], !fu_busy[fu(i)], !grant_vec_out[i], and fu(i) < FU_ARRAY.
REQ-014 Slot 1 SHALL select the first eligible entry scanning from rr_ptr upward, wrapping RS_SIZE-1 -> 0.
REQ-015 Slot 2 SHALL select the next eligible entry after slot 1 in the same scan order whose FU differs from slot 1's FU; at most one grant per FU per cycle.
REQ-016 Slot 2 SHALL be invalid when slot 1 is invalid.
REQ-017 All grant outputs SHALL be registered: requests at edge N appear on outputs after edge N, held exactly one cycle, then cleared unless re-granted.
REQ-018 Invalid slots SHALL drive idx=0, fu=0.
REQ-019 rr_ptr SHALL advance to (last granted index + 1) mod RS_SIZE; unchanged when no grant.
REQ-020 An LSU grant SHALL load lsu_cnt with LSU_LAT-1; lsu_cnt decrements to 0; fu_busy[2] = (lsu_cnt != 0); ALU busy bits always 0.
REQ-021 With LSU_LAT=1, LSU SHALL be grantable every cycle.
REQ-022 Out-of-range FU id (3) SHALL never be granted and SHALL not block other entries.
REQ-023 flush_in SHALL take priority: next edge clears all grant outputs and lsu_cnt, sets rr_ptr=0, no grant that cycle.
REQ-024 All-eligible-same-FU SHALL yield exactly one grant (slot 1).

Reset
REQ-025 rst SHALL asynchronously force grant_valid1/2=0, idx1/2=0, fu1/2=0, grant_vec_out=0, fu_busy_out=0, rr_ptr=0, lsu_cnt=0.
REQ-026 Reset mid-LSU-occupancy SHALL clear busy immediately; first post-reset edge may grant LSU.

Structure
REQ-027 FU id constants (ALU0/ALU1/LSU) and FU_SIZE/FU_ARRAY SHALL live in a shared package used also by the issue queue.
REQ-028 A sub-module rr_find_first (rotating priority find-first with mask, RS_SIZE wide) SHALL be instantiated twice (slot 1, slot 2).

Verification
REQ-029 Entries 3 (ALU0), 5 (ALU1) valid, all FUs ready, rr_ptr=0 -> next cycle slot1 idx=3 fu=0, slot2 idx=5 fu=1, grant_vec=0x0028, rr_ptr=6.
REQ-030 Entries 1,2 both LSU, LSU_LAT=2, requests held -> grant idx=1 cycle N+1, LSU busy cycle N+1 edge, idx=2 granted at cycle N+3; never both same cycle.
REQ-031 rr_ptr=14, entries 15 and 0 ALU0/ALU1 -> slot1 idx=15, slot2 idx=0 (wrap), rr_ptr=1.
REQ-032 fu_ready_in=3'b101, entry 4 ALU1 only request -> no grant, rr_ptr unchanged.
REQ-033 Entry 7 granted, req_valid_in[7] still 1 next cycle -> not re-granted that cycle (masked by grant_vec_out).
REQ-034 flush_in and rst asserted during LSU occupancy -> outputs, fu_busy_out, rr_ptr all 0 on required edge/asynchronously.
